// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------------------------
// instr_encoder
//
// Inverse of the datapath immediate generator. Takes decoded instruction fields (op, rd, rs1,
// rs2, funct3 and a 64-bit signed immediate) and packs them into 32-bit RV64 LD/SD/BEQ words.
// The words are streamed, with sequential word addresses, towards the instruction-memory loader
// used by testbenches and the boot preloader.
//
// Round trip: applying the datapath immediate generator to out_instr yields imm[11:0]
// sign-extended to 64 bits. The BEQ immediate is taken in datapath units, so bit 0 of imm is
// encoded rather than dropped.
//
// Ports
//   clk        in   1         clock, rising edge
//   reset      in   1         synchronous, active-high
//   start      in   1         1-cycle pulse: clear address/err, open (or restart) a program
//   in_valid   in   1         field bundle valid
//   in_ready   out  1         bundle accepted when in_valid & in_ready
//   in_last    in   1         bundle is the final instruction of the program
//   in_op      in   2         0=LD 1=SD 2=BEQ 3=illegal
//   in_rd      in   5         destination register (LD)
//   in_rs1     in   5         base / compare register
//   in_rs2     in   5         store-data / compare register (SD, BEQ)
//   in_funct3  in   3         funct3 field, copied verbatim
//   in_imm     in   2*WIDTH   signed immediate
//   out_valid  out  1         encoded word valid
//   out_ready  in   1         sink accepts when out_valid & out_ready
//   out_instr  out  WIDTH     encoded instruction
//   out_addr   out  ADDR_W    word address of out_instr
//   err_range  out  1         sticky: out-of-range imm or illegal op seen since start
//   done       out  1         1-cycle pulse after the last word is accepted
// ----------------------------------------------------------------------------------------------
module instr_encoder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [1:0]           in_op,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [2*WIDTH-1:0]   in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_instr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 err_range,
    output logic                 done
);

    localparam logic [6:0] OpcLoad   = 7'd3;
    localparam logic [6:0] OpcStore  = 7'd35;
    localparam logic [6:0] OpcBranch = 7'd99;
    localparam logic [WIDTH-1:0] InstrNop = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain
    } state_t;

    state_t              r_state;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_instr;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_err;
    logic                r_done;

    logic                w_accept;
    logic                w_out_hs;
    logic [11:0]         w_imm12;
    logic                w_imm_bad;
    logic                w_err_new;
    logic [WIDTH-1:0]    w_enc;

    // ------------------------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------------------------
    // The output slot is free when empty or being drained this cycle, which gives zero-bubble
    // streaming. start (abort/restart) and reset block acceptance in the same cycle.
    assign in_ready = (r_state == StLoad) && (!r_out_valid || out_ready) && !start && !reset;
    assign w_accept = in_valid && in_ready;
    assign w_out_hs = r_out_valid && out_ready;

    // ------------------------------------------------------------------------------------------
    // Range check and encoding
    // ------------------------------------------------------------------------------------------
    assign w_imm12 = in_imm[11:0];

    // In range iff bits [63:11] are all copies of the sign bit.
    assign w_imm_bad = !((&in_imm[2*WIDTH-1:11]) || !(|in_imm[2*WIDTH-1:11]));
    assign w_err_new = w_imm_bad || (in_op == 2'd3);

    always_comb begin
        w_enc = InstrNop;
        unique case (in_op)
            2'd0: w_enc = {w_imm12, in_rs1, in_funct3, in_rd, OpcLoad};
            2'd1: w_enc = {w_imm12[11:5], in_rs2, in_rs1, in_funct3, w_imm12[4:0], OpcStore};
            2'd2: w_enc = {w_imm12[11], w_imm12[9:4], in_rs2, in_rs1, in_funct3,
                           w_imm12[3:0], w_imm12[10], OpcBranch};
            2'd3: w_enc = InstrNop;
            default: w_enc = InstrNop;
        endcase
    end

    // ------------------------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_addr      <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                // Open a fresh program from any state; a pending word is discarded.
                r_state     <= StLoad;
                r_out_valid <= 1'b0;
                r_addr      <= '0;
                r_err       <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_state <= StIdle;
                    end
                    StLoad: begin
                        if (w_out_hs) begin
                            r_addr <= r_addr + 1'b1;
                        end
                        if (w_accept) begin
                            r_out_instr <= w_enc;
                            r_out_valid <= 1'b1;
                            if (w_err_new) begin
                                r_err <= 1'b1;
                            end
                            if (in_last) begin
                                r_state <= StDrain;
                            end
                        end else if (w_out_hs) begin
                            r_out_valid <= 1'b0;
                        end
                    end
                    StDrain: begin
                        // Only the final word can be held here.
                        if (w_out_hs) begin
                            r_addr      <= r_addr + 1'b1;
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= StIdle;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_addr;
    assign err_range = r_err;
    assign done      = r_done;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int unsigned AddrW = 10;
    localparam int AddrMod = 1 << AddrW;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [1:0]   in_op;
    logic [4:0]   in_rd;
    logic [4:0]   in_rs1;
    logic [4:0]   in_rs2;
    logic [2:0]   in_funct3;
    logic [63:0]  in_imm;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_instr;
    logic [AddrW-1:0] out_addr;
    logic         err_range;
    logic         done;

    always #5 clk = ~clk;

    instr_encoder #(
        .WIDTH  (32),
        .ADDR_W (AddrW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err_range (err_range),
        .done      (done)
    );

    typedef struct {
        logic [1:0]       op;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [2:0]       f3;
        logic [63:0]      imm;
        logic             has_word;
        logic [31:0]      word;
        logic [AddrW-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   exp_addr = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    logic exp_err = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Sink backpressure
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    // Monitor: decode every accepted word and compare against the scoreboard head.
    initial begin
        exp_t e;
        logic [63:0] dimm;
        logic [6:0]  opc;
        forever begin
            @(negedge clk);
            if (!reset && !start && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_word: got=%08h addr=%0d want=no word", out_instr,
                             out_addr);
                end else begin
                    e = sb.pop_front();
                    case (out_instr[6:0])
                        7'd3:  dimm = {{52{out_instr[31]}}, out_instr[31:20]};
                        7'd35: dimm = {{52{out_instr[31]}}, out_instr[31:25], out_instr[11:7]};
                        7'd99: dimm = {{52{out_instr[31]}}, out_instr[31], out_instr[7],
                                       out_instr[30:25], out_instr[11:8]};
                        default: dimm = 'x;
                    endcase
                    if (e.op == 2'd3) begin
                        check("illegal_word", 64'(out_instr), 64'h13);
                    end else begin
                        opc = (e.op == 2'd0) ? 7'd3 : (e.op == 2'd1) ? 7'd35 : 7'd99;
                        check("opcode", 64'(out_instr[6:0]), 64'(opc));
                        check("funct3", 64'(out_instr[14:12]), 64'(e.f3));
                        check("rs1", 64'(out_instr[19:15]), 64'(e.rs1));
                        if (e.op == 2'd0) check("rd", 64'(out_instr[11:7]), 64'(e.rd));
                        else check("rs2", 64'(out_instr[24:20]), 64'(e.rs2));
                        check("imm_roundtrip", dimm, {{52{e.imm[11]}}, e.imm[11:0]});
                    end
                    if (e.has_word) check("word", 64'(out_instr), 64'(e.word));
                    check("addr", 64'(out_addr), 64'(e.addr));
                end
            end
        end
    end

    // Present one bundle and hold it until accepted. Called at posedge+#1.
    task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm,
                        input logic last, input logic has_word, input logic [31:0] word);
        exp_t e;
        int   n = 0;
        logic got = 1'b0;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
        in_last = last;
        in_valid = 1'b1;
        while (!got) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got = 1'b1;
                e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.imm = imm;
                e.has_word = has_word; e.word = word; e.addr = AddrW'(exp_addr);
                exp_addr = (exp_addr + 1) % AddrMod;
                sb.push_back(e);
                if (op == 2'd3 || !((&imm[63:11]) || !(|imm[63:11]))) exp_err = 1'b1;
            end else if (++n > 500) begin
                got = 1'b1;
                total++;
                bad++;
                $display("FAIL accept_timeout: got=in_ready low for %0d cycles want=accept", n);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.delete();
        exp_addr = 0;
        exp_err = 1'b0;
    endtask

    // Wait (bounded) for done, then confirm it was a single pulse and everything drained.
    task automatic wait_done(input string name);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int d_before;
        int v;
        int highs;
        logic [1:0] op;
        logic [63:0] imm;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_op = '0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_err", 64'(err_range), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: single LD program
        ready_mode = 0;
        pulse_start();
        send(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 64'd8, 1'b1, 1'b1, 32'h0081_3283);
        wait_done("t1");

        // 2: SD then BEQ
        pulse_start();
        send(2'd1, 5'd0, 5'd2, 5'd6, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 32'hFE61_3E23);
        send(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 32'hFE20_8EE3);
        wait_done("t2");
        check("t2_err", 64'(err_range), 64'd0);

        // 3: range error and illegal op, sticky until next start
        pulse_start();
        send(2'd0, 5'd1, 5'd0, 5'd0, 3'd3, 64'd2048, 1'b0, 1'b1, 32'h8000_3083);
        check("t3_err_after_2048", 64'(err_range), 64'd1);
        send(2'd3, 5'd7, 5'd7, 5'd7, 3'd7, 64'd1, 1'b1, 1'b1, 32'h0000_0013);
        wait_done("t3");
        check("t3_err_sticky", 64'(err_range), 64'd1);
        // in_valid in IDLE must be ignored
        in_valid = 1'b1;
        highs = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready !== 1'b0) highs++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t3_idle_in_ready", 64'(highs), 64'd0);
        pulse_start();
        check("t3_err_cleared", 64'(err_range), 64'd0);

        // 4: random backpressure stream, long enough to wrap the address counter
        ready_mode = 1;
        for (int i = 0; i < 1030; i++) begin
            op = (i % 97 == 50) ? 2'd3 : 2'($urandom_range(0, 2));
            if (i % 50 == 25) begin
                imm = {32'($urandom), 32'($urandom)};
            end else begin
                v = int'($urandom_range(0, 4095)) - 2048;
                imm = {{32{v[31]}}, v};
            end
            send(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm,
                 1'(i == 1029), 1'b0, 32'd0);
        end
        wait_done("t4");
        check("t4_err", 64'(err_range), 64'(exp_err));
        check("t4_addr_after_wrap", 64'(out_addr), 64'd6);

        // 5: abort mid-LOAD with a held output word
        pulse_start();
        ready_mode = 2;
        d_before = done_cnt;
        send(2'd0, 5'd3, 5'd4, 5'd0, 3'd3, 64'd16, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t5_held_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b1;
        in_valid = 1'b1;
        in_op = 2'd1; in_imm = 64'd4; in_last = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        exp_addr = 0;
        exp_err = 1'b0;
        check("t5_valid_dropped", 64'(out_valid), 64'd0);
        check("t5_addr_cleared", 64'(out_addr), 64'd0);
        ready_mode = 0;
        send(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 64'd8, 1'b1, 1'b1, 32'h0081_3283);
        wait_done("t5");
        check("t5_total_done", 64'(done_cnt - d_before), 64'd1);

        // 6: reset (with a simultaneous start) while in DRAIN
        pulse_start();
        ready_mode = 2;
        send(2'd1, 5'd0, 5'd9, 5'd10, 3'd3, 64'd12, 1'b1, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        d_before = done_cnt;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_out_instr", 64'(out_instr), 64'd0);
        check("t6_out_addr", 64'(out_addr), 64'd0);
        check("t6_err", 64'(err_range), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        sb.delete();
        ready_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        check("t6_idle_in_ready", 64'(in_ready), 64'd0);
        check("t6_no_done", 64'(done_cnt - d_before), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
